lfsr_tx_sequencer: RTL and testbench

- Sequences the 16-bit LFSR pseudo-random byte source into the UART transmitter, sending bursts of N pseudo-random bytes for link testing.
- Steps the LFSR a programmable number of bits per byte, captures its low byte, and hands the byte to UART TX using the TX data-valid/active/done handshake.
- Inserts a programmable idle gap between bytes; supports start, abort and progress reporting.
- Sits between the LFSR instance (its i_Enable and o_LFSR_Byte) and the UART TX.

---
 rtl/lfsr_seq_pkg.sv | 22 ++
 rtl/seq_down_counter.sv | 28 ++
 rtl/lfsr_tx_sequencer.sv | 174 +++++++++++++++++
 tb/tb_lfsr_tx_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_pkg.sv
// Shared types and defaults for the LFSR-to-UART burst sequencer.
// The state encoding is exported so a debug port can present it directly.
package lfsr_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADVANCE   = 3'd1,
      ST_LOAD      = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5,
      ST_FINISH    = 3'd6
   } seq_state_t;

   localparam int DEF_STEPS_PER_BYTE = 8;
   localparam int DEF_GAP_CYCLES     = 16;
   localparam int DEF_COUNT_WIDTH    = 16;

   // Width of the shared step/gap timer; wide enough for any practical gap.
   localparam int TIMER_WIDTH        = 16;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
// The sequencer shares one instance between LFSR stepping and inter-byte gaps.
module seq_down_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/lfsr_tx_sequencer.sv
// Sends bursts of pseudo-random bytes: steps an external LFSR, captures its low
// byte and hands it to a UART transmitter, with an idle gap between bytes.
//
// Handshake: o_TX_DV is a single-cycle strobe issued only while the transmitter
// reports i_TX_Active = 0; the frame is then owned by the transmitter until its
// single-cycle i_TX_Done pulse, which is the only event that advances the count.
module lfsr_tx_sequencer
   import lfsr_seq_pkg::*;
#(
   parameter int STEPS_PER_BYTE = DEF_STEPS_PER_BYTE,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
   input  logic                   i_Clock,
   input  logic                   i_Rst_L,
   input  logic                   i_Start,
   input  logic                   i_Abort,
   input  logic [COUNT_WIDTH-1:0] i_Burst_Len,
   output logic                   o_LFSR_Enable,
   input  logic [7:0]             i_LFSR_Byte,
   output logic                   o_TX_DV,
   output logic [7:0]             o_TX_Byte,
   input  logic                   i_TX_Active,
   input  logic                   i_TX_Done,
   output logic                   o_Busy,
   output logic                   o_Done,
   output logic [COUNT_WIDTH-1:0] o_Bytes_Sent,
   output logic [2:0]             o_State
);

   // Timer is loaded with N-1 on entry so the state lasts exactly N cycles.
   localparam logic [TIMER_WIDTH-1:0] STEPS_LOAD = TIMER_WIDTH'(STEPS_PER_BYTE - 1);
   localparam logic [TIMER_WIDTH-1:0] GAP_LOAD   =
      TIMER_WIDTH'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   seq_state_t             state, state_next;
   logic [COUNT_WIDTH-1:0] burst_len;
   logic [COUNT_WIDTH-1:0] count_inc;
   logic                   abort_pending;

   logic                   tmr_load, tmr_dec, tmr_zero;
   logic [TIMER_WIDTH-1:0] tmr_load_value;
   logic                   capture, clear_count, inc_count, latch_len;
   logic                   abort_set, abort_clr;

   seq_down_counter #(.WIDTH(TIMER_WIDTH)) u_timer (
      .clk        (i_Clock),
      .rst_n      (i_Rst_L),
      .load       (tmr_load),
      .load_value (tmr_load_value),
      .dec        (tmr_dec),
      .zero       (tmr_zero)
   );

   assign count_inc = o_Bytes_Sent + 1'b1;
   assign o_Busy    = (state != ST_IDLE);
   assign o_State   = state;

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      tmr_load       = 1'b0;
      tmr_load_value = STEPS_LOAD;
      tmr_dec        = 1'b0;
      capture        = 1'b0;
      clear_count    = 1'b0;
      inc_count      = 1'b0;
      latch_len      = 1'b0;
      abort_set      = 1'b0;
      abort_clr      = 1'b0;
      o_LFSR_Enable  = 1'b0;
      o_TX_DV        = 1'b0;
      o_Done         = 1'b0;

      case (state)
         ST_IDLE: begin
            if (i_Start && !i_Abort) begin
               clear_count = 1'b1;
               if (i_Burst_Len != '0) begin
                  latch_len  = 1'b1;
                  tmr_load   = 1'b1;
                  state_next = ST_ADVANCE;
               end else begin
                  state_next = ST_FINISH;
               end
            end
         end
         ST_ADVANCE: begin
            if (i_Abort) begin
               state_next = ST_IDLE;
            end else begin
               o_LFSR_Enable = 1'b1;
               if (tmr_zero) state_next = ST_LOAD;
               else          tmr_dec    = 1'b1;
            end
         end
         ST_LOAD: begin
            if (i_Abort) begin
               state_next = ST_IDLE;
            end else if (!i_TX_Active) begin
               capture    = 1'b1;
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (i_Abort) begin
               state_next = ST_IDLE;
            end else begin
               o_TX_DV    = 1'b1;
               state_next = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            // An abort here only takes effect once the frame in flight completes.
            abort_set = i_Abort;
            if (i_TX_Done) begin
               inc_count = 1'b1;
               abort_clr = 1'b1;
               if (abort_pending || i_Abort) begin
                  state_next = ST_IDLE;
               end else if (count_inc == burst_len) begin
                  state_next = ST_FINISH;
               end else if (GAP_CYCLES == 0) begin
                  tmr_load   = 1'b1;
                  state_next = ST_ADVANCE;
               end else begin
                  tmr_load       = 1'b1;
                  tmr_load_value = GAP_LOAD;
                  state_next     = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (i_Abort) begin
               state_next = ST_IDLE;
            end else if (tmr_zero) begin
               tmr_load   = 1'b1;
               state_next = ST_ADVANCE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_FINISH: begin
            o_Done     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_TX_Byte     <= '0;
         o_Bytes_Sent  <= '0;
         burst_len     <= '0;
         abort_pending <= 1'b0;
      end else begin
         if (capture)     o_TX_Byte    <= i_LFSR_Byte;
         if (latch_len)   burst_len    <= i_Burst_Len;
         if (clear_count) o_Bytes_Sent <= '0;
         else if (inc_count) o_Bytes_Sent <= count_inc;
         if (abort_clr)      abort_pending <= 1'b0;
         else if (abort_set) abort_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lfsr_tx_sequencer.sv
// Directed bench for lfsr_tx_sequencer with a behavioural 16-bit LFSR and a
// UART TX model that reports done 20 cycles after each strobe.
module tb_lfsr_tx_sequencer;
   import lfsr_seq_pkg::*;

   localparam int STEPS = 8;
   localparam int GAP   = 16;
   localparam int CW    = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          i_Start = 1'b0, i_Abort = 1'b0;
   logic [CW-1:0] i_Burst_Len = '0;
   logic          o_LFSR_Enable, o_TX_DV, o_Busy, o_Done;
   logic [7:0]    o_TX_Byte, i_LFSR_Byte;
   logic          i_TX_Active, i_TX_Done;
   logic [CW-1:0] o_Bytes_Sent;
   logic [2:0]    o_State;

   lfsr_tx_sequencer #(.STEPS_PER_BYTE(STEPS), .GAP_CYCLES(GAP), .COUNT_WIDTH(CW)) dut (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_Start(i_Start), .i_Abort(i_Abort),
      .i_Burst_Len(i_Burst_Len), .o_LFSR_Enable(o_LFSR_Enable), .i_LFSR_Byte(i_LFSR_Byte),
      .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .i_TX_Active(i_TX_Active),
      .i_TX_Done(i_TX_Done), .o_Busy(o_Busy), .o_Done(o_Done),
      .o_Bytes_Sent(o_Bytes_Sent), .o_State(o_State)
   );

   // ---------------- external LFSR and UART TX models ----------------
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ~(v[15] ^ v[14] ^ v[12] ^ v[3])};
   endfunction

   logic [15:0] lfsr = 16'h0000;
   always @(posedge clk) if (o_LFSR_Enable) lfsr <= lfsr_next(lfsr);
   assign i_LFSR_Byte = lfsr[7:0];

   logic tx_busy = 1'b0, tx_done = 1'b0, force_active = 1'b0;
   int   tx_cnt = 0;
   assign i_TX_Active = tx_busy | force_active;
   assign i_TX_Done   = tx_done;

   // ---------------- monitor (samples 2 time units after each rising edge) ----------------
   int cyc, en_cnt, dv_cnt, done_cnt, first_dv, done_cyc, busy_fall_cyc;
   logic prev_busy = 1'b0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   always begin
      @(posedge clk);
      #2;
      cyc++;
      if (o_LFSR_Enable) en_cnt++;
      if (o_TX_DV) begin
         dv_cnt++;
         got_q.push_back(o_TX_Byte);
         if (first_dv < 0) first_dv = cyc;
      end
      if (o_Done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (prev_busy && !o_Busy) busy_fall_cyc = cyc;
      prev_busy = o_Busy;
      tx_done = 1'b0;
      if (o_TX_DV) begin
         tx_busy = 1'b1;
         tx_cnt  = 20;
      end else if (tx_busy) begin
         tx_cnt--;
         if (tx_cnt == 0) begin
            tx_busy = 1'b0;
            tx_done = 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_burst(input int len);
      logic [15:0] v;
      @(negedge clk);
      i_Start = 1'b1;
      i_Burst_Len = CW'(len);
      cyc = 0; en_cnt = 0; dv_cnt = 0; done_cnt = 0;
      first_dv = -1; done_cyc = -1; busy_fall_cyc = -1;
      got_q.delete();
      exp_q.delete();
      v = lfsr;
      for (int k = 0; k < len; k++) begin
         repeat (STEPS) v = lfsr_next(v);
         exp_q.push_back(v[7:0]);
      end
      @(negedge clk);
      i_Start = 1'b0;
   endtask

   task automatic pulse_abort();
      @(negedge clk);
      i_Abort = 1'b1;
      @(negedge clk);
      i_Abort = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && o_Busy; i++) @(negedge clk);
      check(tag, o_Busy, 0);
   endtask

   task automatic compare_bytes(input string tag, input int n);
      check({tag, "_nbytes"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_byte"}, got_q[i], exp_q[i]);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      cycles(3);
      check("rst_busy", o_Busy, 0);
      check("rst_en_dv_done", {o_LFSR_Enable, o_TX_DV, o_Done}, 0);
      check("rst_byte", o_TX_Byte, 0);
      check("rst_count", o_Bytes_Sent, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(2);

      // Three-byte burst, idle transmitter
      start_burst(3);
      wait_idle("t1_idle", 400);
      check("t1_first_dv", first_dv, 10);
      check("t1_dv_cnt", dv_cnt, 3);
      check("t1_en_cnt", en_cnt, 3 * STEPS);
      compare_bytes("t1", 3);
      check("t1_sent", o_Bytes_Sent, 3);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_busy_fall", busy_fall_cyc, done_cyc + 1);

      // Transmitter busy: byte held back in LOAD
      force_active = 1'b1;
      start_burst(1);
      cycles(48);
      check("t2_in_load", o_State, ST_LOAD);
      check("t2_no_dv", dv_cnt, 0);
      check("t2_en_held", en_cnt, STEPS);
      force_active = 1'b0;
      wait_idle("t2_idle", 200);
      check("t2_dv_cnt", dv_cnt, 1);
      check("t2_en_cnt", en_cnt, STEPS);
      compare_bytes("t2", 1);
      check("t2_sent", o_Bytes_Sent, 1);
      check("t2_done_cnt", done_cnt, 1);

      // Abort during the gap after the first of five bytes
      start_burst(5);
      for (int i = 0; i < 300 && o_State != ST_GAP; i++) @(negedge clk);
      check("t3_reach_gap", o_State, ST_GAP);
      cycles(3);
      pulse_abort();
      check("t3_idle_next", o_Busy, 0);
      cycles(40);
      check("t3_sent", o_Bytes_Sent, 1);
      check("t3_no_done", done_cnt, 0);
      check("t3_dv_cnt", dv_cnt, 1);
      check("t3_en_cnt", en_cnt, STEPS);

      // Abort while the second frame is in flight
      start_burst(5);
      for (int i = 0; i < 300 && dv_cnt < 2; i++) @(negedge clk);
      check("t4_second_dv", dv_cnt, 2);
      cycles(3);
      pulse_abort();
      check("t4_still_wait", o_State, ST_WAIT_DONE);
      wait_idle("t4_idle", 100);
      check("t4_sent", o_Bytes_Sent, 2);
      check("t4_no_done", done_cnt, 0);
      cycles(30);
      check("t4_en_cnt", en_cnt, 2 * STEPS);
      check("t4_dv_cnt", dv_cnt, 2);

      // Start and abort together in IDLE
      @(negedge clk);
      i_Start = 1'b1; i_Abort = 1'b1; i_Burst_Len = CW'(4);
      @(negedge clk);
      i_Start = 1'b0; i_Abort = 1'b0;
      check("t5_start_abort_idle", o_Busy, 0);
      check("t5_start_abort_count", o_Bytes_Sent, 2);

      // Zero-length burst
      start_burst(0);
      check("t5_len0_done", o_Done, 1);
      check("t5_len0_count", o_Bytes_Sent, 0);
      @(negedge clk);
      check("t5_len0_idle", {o_Busy, o_Done}, 0);
      cycles(5);
      check("t5_len0_no_en_dv", en_cnt + dv_cnt, 0);

      // Abort in ADVANCE gates the enable in the same cycle
      start_burst(1);
      cycles(2);
      @(negedge clk);
      i_Abort = 1'b1;
      #1;
      check("t5b_en_dropped", o_LFSR_Enable, 0);
      @(negedge clk);
      i_Abort = 1'b0;
      check("t5b_idle", o_Busy, 0);
      cycles(20);
      check("t5b_no_dv", dv_cnt, 0);

      // Asynchronous reset in the middle of ADVANCE, then a clean burst
      start_burst(2);
      cycles(2);
      #3;
      check("t6_pre_en", o_LFSR_Enable, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_en", o_LFSR_Enable, 0);
      check("t6_rst_busy", o_Busy, 0);
      check("t6_rst_state", o_State, ST_IDLE);
      check("t6_rst_byte_count", {o_TX_Byte, o_Bytes_Sent}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(2);
      start_burst(2);
      wait_idle("t6_idle", 300);
      check("t6_dv_cnt", dv_cnt, 2);
      check("t6_en_cnt", en_cnt, 2 * STEPS);
      compare_bytes("t6", 2);
      check("t6_sent", o_Bytes_Sent, 2);
      check("t6_done_cnt", done_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
